fetch_pc_ctrl: RTL and testbench

Fetch-stage PC owner for the single-cycle RV64 core. Sits directly upstream of access_instruction_memory and drives its pc_i.
Holds the architectural PC and selects the next PC (sequential, branch, JAL, JALR). Consumes the memory's imem_error_o and runs a sticky status FSM. Keeps retired-instruction and cycle counters.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc_ctrl_next_pc_sel.sv | 37 +++
 rtl/fetch_pc_ctrl.sv | 94 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC controller.
//   PC_W        : architectural PC / counter width
//   PC_STEP_DEF : default sequential increment in bytes (no C extension)
//   stat_t      : fetch status encoding driven on stat_o
package fetch_pkg;

   localparam int unsigned PC_W = 64;
   localparam logic [PC_W-1:0] PC_STEP_DEF = 64'd4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_HALT     = 2'b01,
      ST_IMEM_ERR = 2'b10,
      ST_MISALIGN = 2'b11
   } stat_t;

endpackage

// File: rtl/fetch_pc_ctrl_next_pc_sel.sv
// next_pc_sel: combinational next-PC target computation and priority mux.
// Priority: jalr > jal > branch_taken > sequential. All adds wrap mod 2^PC_W.
// Ports:
//   pc, imm, rs1          : current PC, sign-extended immediate, JALR base
//   jal, jalr, branch_taken : control-transfer selects
//   pc_next               : selected candidate next PC
//   misaligned            : pc_next is not 4-byte aligned
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] PC_STEP = PC_STEP_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] imm,
   input  logic [PC_W-1:0] rs1,
   input  logic            jal,
   input  logic            jalr,
   input  logic            branch_taken,
   output logic [PC_W-1:0] pc_next,
   output logic            misaligned
);

   logic [PC_W-1:0] jalr_sum;

   always_comb begin
      jalr_sum = rs1 + imm;
      pc_next  = pc + PC_STEP;
      if (jalr) begin
         // JALR target has bit 0 forced to zero
         pc_next = {jalr_sum[PC_W-1:1], 1'b0};
      end else if (jal || branch_taken) begin
         pc_next = pc + imm;
      end
      misaligned = (pc_next[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC owner. Holds the architectural PC, selects the
// next PC, runs a sticky status FSM and keeps instret/cycle counters.
// Ports:
//   clk_i, rst_i         : clock (rising edge), synchronous active-high reset
//   stall_i              : hold PC and instret this cycle
//   halt_i               : ECALL/EBREAK decoded at current PC
//   imem_error_i         : instruction memory error
//   branch_taken_i, jal_i, jalr_i, imm_i, rs1_i : next-PC controls/operands
//   pc_o                 : current PC to instruction memory
//   pc_next_o            : combinational candidate next PC
//   stat_o               : 00 RUN, 01 HALT, 10 IMEM_ERR, 11 MISALIGN
//   instret_o, cycle_o   : retired-instruction count, cycles spent in RUN
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 64'h0,
   parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            imem_error_i,
   input  logic            branch_taken_i,
   input  logic            jal_i,
   input  logic            jalr_i,
   input  logic [PC_W-1:0] imm_i,
   input  logic [PC_W-1:0] rs1_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_next_o,
   output logic [1:0]      stat_o,
   output logic [PC_W-1:0] instret_o,
   output logic [PC_W-1:0] cycle_o
);

   stat_t           stat_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] instret_q;
   logic [PC_W-1:0] cycle_q;
   logic [PC_W-1:0] pc_next;
   logic            misaligned;

   next_pc_sel #(
      .PC_STEP (PC_STEP)
   ) u_next_pc_sel (
      .pc           (pc_q),
      .imm          (imm_i),
      .rs1          (rs1_i),
      .jal          (jal_i),
      .jalr         (jalr_i),
      .branch_taken (branch_taken_i),
      .pc_next      (pc_next),
      .misaligned   (misaligned)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_q    <= ST_RUN;
         pc_q      <= RESET_PC;
         instret_q <= '0;
         cycle_q   <= '0;
      end else begin
         case (stat_q)
            ST_RUN: begin
               cycle_q <= cycle_q + 64'd1;
               // stall outranks every event, including a memory error
               if (!stall_i) begin
                  if (imem_error_i) begin
                     stat_q <= ST_IMEM_ERR;
                  end else if (halt_i) begin
                     stat_q    <= ST_HALT;
                     instret_q <= instret_q + 64'd1;
                  end else if (misaligned) begin
                     stat_q <= ST_MISALIGN;
                  end else begin
                     pc_q      <= pc_next;
                     instret_q <= instret_q + 64'd1;
                  end
               end
            end
            default: begin
               // terminal states: everything frozen until reset
            end
         endcase
      end
   end

   assign pc_o      = pc_q;
   assign pc_next_o = pc_next;
   assign stat_o    = stat_q;
   assign instret_o = instret_q;
   assign cycle_o   = cycle_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] ir;
      logic [63:0] cy;
      logic [1:0]  st;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        halt_i = 1'b0;
   logic        imem_error_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic        jal_i = 1'b0;
   logic        jalr_i = 1'b0;
   logic [63:0] imm_i = '0;
   logic [63:0] rs1_i = '0;
   logic [63:0] pc_o;
   logic [63:0] pc_next_o;
   logic [1:0]  stat_o;
   logic [63:0] instret_o;
   logic [63:0] cycle_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   exp_t        sq[$];
   logic [63:0] nq[$];

   // reference model state: st 0 RUN, 1 HALT, 2 IMEM_ERR, 3 MISALIGN
   logic [63:0] m_pc, m_ir, m_cy;
   int          m_st;
   bit          m_valid = 0;

   fetch_pc_ctrl #(
      .RESET_PC (64'h0),
      .PC_STEP  (64'd4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_i        (stall_i),
      .halt_i         (halt_i),
      .imem_error_i   (imem_error_i),
      .branch_taken_i (branch_taken_i),
      .jal_i          (jal_i),
      .jalr_i         (jalr_i),
      .imm_i          (imm_i),
      .rs1_i          (rs1_i),
      .pc_o           (pc_o),
      .pc_next_o      (pc_next_o),
      .stat_o         (stat_o),
      .instret_o      (instret_o),
      .cycle_o        (cycle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // combinational pc_next monitor
   initial forever begin
      @(negedge clk_i);
      #1;
      if (nq.size() > 0) chk("pc_next", pc_next_o, nq.pop_front());
   end

   // registered-state monitor
   initial forever begin
      exp_t e;
      @(posedge clk_i);
      #1;
      if (sq.size() > 0) begin
         e = sq.pop_front();
         chk("pc", pc_o, e.pc);
         chk("stat", {62'd0, stat_o}, {62'd0, e.st});
         chk("instret", instret_o, e.ir);
         chk("cycle", cycle_o, e.cy);
      end
   end

   // one clock of stimulus: drive inputs, push expectations, advance the model
   task automatic cyc(input bit rst, input bit stall, input bit halt, input bit err,
                      input bit br, input bit jal, input bit jalr,
                      input logic [63:0] imm, input logic [63:0] rs1);
      logic [63:0] tgt;
      exp_t e;
      @(negedge clk_i);
      rst_i = rst; stall_i = stall; halt_i = halt; imem_error_i = err;
      branch_taken_i = br; jal_i = jal; jalr_i = jalr; imm_i = imm; rs1_i = rs1;

      if (jalr)            tgt = (rs1 + imm) & ~64'h1;
      else if (jal || br)  tgt = m_pc + imm;
      else                 tgt = m_pc + 64'd4;
      if (m_valid) nq.push_back(tgt);

      if (rst) begin
         m_pc = 64'h0; m_ir = 0; m_cy = 0; m_st = 0; m_valid = 1;
      end else if (m_st == 0) begin
         m_cy = m_cy + 1;
         if (!stall) begin
            if (err)                   m_st = 2;
            else if (halt) begin       m_st = 1; m_ir = m_ir + 1; end
            else if (tgt % 4 != 0)     m_st = 3;
            else begin                 m_pc = tgt; m_ir = m_ir + 1; end
         end
      end
      e.pc = m_pc; e.ir = m_ir; e.cy = m_cy; e.st = 2'(m_st);
      sq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic jump_to(input logic [63:0] a);
      cyc(0, 0, 0, 0, 0, 0, 1, a, 64'h0);
   endtask

   initial begin
      logic [63:0] imm, rs1;
      int s;

      // reset then sequential fetch 0,4,8,12
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
      idle(3);
      // branch/jal priority
      jump_to(64'h100);
      cyc(0, 0, 0, 0, 1, 0, 0, -64'sd8, '0);     // 0xF8
      jump_to(64'h100);
      cyc(0, 0, 0, 0, 1, 1, 0, 64'h40, '0);      // jal wins -> 0x140
      // jalr LSB clear, then misalign
      cyc(0, 0, 0, 0, 1, 1, 1, 64'h4, 64'h2001); // 0x2004
      cyc(0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h2002); // MISALIGN
      idle(2);
      // error beats halt, then frozen
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
      idle(2);
      cyc(0, 0, 1, 1, 0, 0, 0, '0, '0);
      cyc(0, 0, 0, 0, 1, 0, 0, 64'h40, '0);
      cyc(0, 0, 0, 0, 1, 1, 1, 64'h80, 64'h10);
      // stall holds, error under stall deferred
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
      jump_to(64'h40);
      for (int i = 0; i < 5; i++) cyc(0, 1, i[0], i[1], 1, 0, 0, 64'h8, '0);
      cyc(0, 0, 0, 1, 0, 0, 0, '0, '0);          // error taken now
      // halt then reset, sequential resumes
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
      jump_to(64'h80);
      cyc(0, 0, 1, 0, 0, 0, 0, '0, '0);
      idle(2);
      cyc(1, 0, 0, 0, 0, 0, 0, '0, '0);
      idle(2);
      // wraparound at the top of the address space
      jump_to(64'hFFFF_FFFF_FFFF_FFFC);
      idle(2);
      // misalign via branch offset
      cyc(0, 0, 0, 0, 1, 0, 0, 64'h2, '0);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s = int'($urandom_range(0, 2000)) - 1000;
         imm = 64'(longint'(s)) << 2;
         if ($urandom_range(0, 9) == 0) imm = imm + 64'($urandom_range(1, 3));
         rs1 = {$urandom, $urandom};
         if ($urandom_range(0, 9) != 0) rs1 = rs1 & ~64'h3;
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, imm, rs1);
      end

      repeat (3) @(posedge clk_i);
      #2;
      chk("drain", 64'(sq.size() + nq.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
